// File: rtl/cv32e40p_instr_fifo.sv
// Instruction prefetch FIFO between the OBI fetch port and the aligner.
// An empty FIFO passes the incoming word straight through, and each entry can carry an even-parity bit.
module cv32e40p_instr_fifo #(
    parameter int DEPTH     = 4,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    input  logic [31:0]                in_rdata_i,
    input  logic                       in_err_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [31:0]                out_rdata_o,
    output logic                       out_err_o,
    output logic [$clog2(DEPTH):0]     cnt_o,
    output logic                       full_o,
    output logic                       overflow_o,
    output logic                       parity_err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] err_q;
    logic [PW-1:0]    rptr_q, wptr_q;
    logic [CW-1:0]    cnt_q;
    logic             overflow_q;

    logic             empty, full, fall_through, bypass_taken;
    logic             push, pop, wr_en, overflow_d;
    logic [31:0]      head_data;
    logic             head_err;
    logic             head_par_err;

    assign empty        = (cnt_q == '0);
    assign full         = (cnt_q == CW'(DEPTH));
    assign fall_through = empty & in_valid_i & ~flush_i;
    assign bypass_taken = fall_through & out_ready_i;

    assign head_data = data_q[rptr_q];
    assign head_err  = err_q[rptr_q];

    // Flush blanks the output in the same cycle so the aligner never sees a stale-path word
    assign out_valid_o = ~flush_i & (~empty | in_valid_i);
    assign out_rdata_o = empty ? in_rdata_i : head_data;
    assign out_err_o   = empty ? in_err_i   : (head_err | head_par_err);

    assign push = in_valid_i & ~flush_i & ~bypass_taken;
    assign pop  = out_valid_o & out_ready_i & ~empty;

    // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle
    assign wr_en      = push & (~full | pop);
    assign overflow_d = push & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q     <= '0;
            wptr_q     <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            err_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else if (flush_i) begin
            rptr_q     <= '0;
            wptr_q     <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            if (wr_en) begin
                data_q[wptr_q] <= in_rdata_i;
                err_q[wptr_q]  <= in_err_i;
                wptr_q         <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            if (wr_en && !pop) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (pop && !wr_en) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    generate
        if (PARITY_EN) begin : g_parity
            logic [DEPTH-1:0] par_q;
            logic             par_err_q;
            logic             par_in;

            assign par_in       = ^{in_err_i, in_rdata_i};
            assign head_par_err = ~empty & ((^{head_err, head_data}) != par_q[rptr_q]);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    par_q     <= '0;
                    par_err_q <= 1'b0;
                end else if (flush_i) begin
                    par_err_q <= 1'b0;
                end else begin
                    par_err_q <= pop & head_par_err;
                    if (wr_en) begin
                        par_q[wptr_q] <= par_in;
                    end
                end
            end

            assign parity_err_o = par_err_q;
        end else begin : g_no_parity
            assign head_par_err = 1'b0;
            assign parity_err_o = 1'b0;
        end
    endgenerate

    assign cnt_o      = cnt_q;
    assign full_o     = full;
    assign overflow_o = overflow_q;

endmodule
